// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, default frame header
// and error codes, reused by the bitty top and debug logic.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StDataHi,
        StDataLo,
        StCheck,
        StDone,
        StErr
    } state_e;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // A count byte of 0 means 256 words; the 8-bit wrap of wcnt+1 handles that for free.
    function automatic logic last_word(input logic [7:0] wcnt, input logic [7:0] n);
        return (wcnt + 8'd1) == n;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write / status outputs of the loader.
interface prog_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        load_done;
    logic        load_err;
    logic [1:0]  err_code;
    logic        cpu_hold;

    // master: the UART side that feeds bytes and observes the loader.
    modport master (
        output rx_data, rx_valid,
        input  mem_we, mem_addr, mem_wdata, busy, load_done, load_err, err_code, cpu_hold
    );

    modport slave (
        input  rx_data, rx_valid,
        output mem_we, mem_addr, mem_wdata, busy, load_done, load_err, err_code, cpu_hold
    );
endinterface

// File: rtl/prog_loader_timeout.sv
// Reloadable down-counter: expired asserts once Cycles idle clocks pass without a reload.
module loader_timeout #(
    parameter int unsigned Cycles = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic reload,
    output logic expired
);
    localparam int unsigned Width = (Cycles > 1) ? $clog2(Cycles) : 1;
    localparam logic [Width-1:0] Load = Width'(Cycles - 1);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= Load;
        end else if (reload || !enable) begin
            count_q <= Load;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    // A byte arriving on the expiry edge wins over the timeout.
    assign expired = enable && !reload && (count_q == '0);

endmodule

// File: rtl/prog_loader.sv
// Frames a UART byte stream (header, count, big-endian words, XOR checksum) into
// instruction-memory writes and holds the CPU in reset until the image verifies.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  HEADER         = HEADER_DEFAULT
) (
    input logic         clk,
    input logic         reset,
    prog_loader_if.slave bus
);
    state_e      state_q;
    logic [7:0]  n_q;
    logic [7:0]  wcnt_q;
    logic [7:0]  hi_q;
    logic [7:0]  csum_q;
    logic        mem_we_q;
    logic [7:0]  mem_addr_q;
    logic [15:0] mem_wdata_q;
    logic        busy_q;
    logic        load_done_q;
    logic        load_err_q;
    logic [1:0]  err_code_q;
    logic        cpu_hold_q;
    logic        in_frame;
    logic        expired;

    assign in_frame = (state_q == StCount) || (state_q == StDataHi) ||
                      (state_q == StDataLo) || (state_q == StCheck);

    loader_timeout #(
        .Cycles (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .enable  (in_frame),
        .reload  (bus.rx_valid),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            n_q         <= '0;
            wcnt_q      <= '0;
            hi_q        <= '0;
            csum_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            err_code_q  <= ERR_NONE;
            cpu_hold_q  <= 1'b1;
        end else begin
            mem_we_q <= 1'b0;
            // Address advances on the edge after the write cycle.
            if (mem_we_q) begin
                mem_addr_q <= mem_addr_q + 8'd1;
            end
            case (state_q)
                StIdle, StDone, StErr: begin
                    if (bus.rx_valid && (bus.rx_data == HEADER)) begin
                        state_q     <= StCount;
                        csum_q      <= '0;
                        wcnt_q      <= '0;
                        mem_addr_q  <= '0;
                        load_done_q <= 1'b0;
                        load_err_q  <= 1'b0;
                        err_code_q  <= ERR_NONE;
                        busy_q      <= 1'b1;
                        cpu_hold_q  <= 1'b1;
                    end
                end
                default: begin
                    if (expired) begin
                        state_q    <= StErr;
                        busy_q     <= 1'b0;
                        load_err_q <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                    end else if (bus.rx_valid) begin
                        case (state_q)
                            StCount: begin
                                n_q     <= bus.rx_data;
                                state_q <= StDataHi;
                            end
                            StDataHi: begin
                                hi_q    <= bus.rx_data;
                                csum_q  <= csum_q ^ bus.rx_data;
                                state_q <= StDataLo;
                            end
                            StDataLo: begin
                                csum_q      <= csum_q ^ bus.rx_data;
                                mem_wdata_q <= {hi_q, bus.rx_data};
                                mem_we_q    <= 1'b1;
                                wcnt_q      <= wcnt_q + 8'd1;
                                state_q     <= last_word(wcnt_q, n_q) ? StCheck : StDataHi;
                            end
                            default: begin
                                busy_q <= 1'b0;
                                if (bus.rx_data == csum_q) begin
                                    state_q     <= StDone;
                                    load_done_q <= 1'b1;
                                    cpu_hold_q  <= 1'b0;
                                end else begin
                                    state_q    <= StErr;
                                    load_err_q <= 1'b1;
                                    err_code_q <= ERR_CSUM;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
    assign bus.load_done = load_done_q;
    assign bus.load_err  = load_err_q;
    assign bus.err_code  = err_code_q;
    assign bus.cpu_hold  = cpu_hold_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of two-word frames plus hand-written
// timeout, 256-word, reset-abort and garbage-byte sequences.
module tb_prog_loader;
    localparam int unsigned TO = 50;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   wr_count;
    logic [15:0] mem_seen [256];

    prog_loader_if bus ();

    prog_loader #(
        .TIMEOUT_CYCLES (TO),
        .HEADER         (8'hA5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            mem_seen[bus.mem_addr] <= bus.mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        logic [7:0]  csum;
        logic        exp_done;
        logic        exp_err;
        logic [1:0]  exp_code;
        logic        exp_hold;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Byte is sampled on the next rising edge; returns at that edge + 1.
    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " mem_we"}, bus.mem_we, 1'b0);
        check({tag, " mem_addr"}, bus.mem_addr, 8'h00);
        check({tag, " mem_wdata"}, bus.mem_wdata, 16'h0000);
        check({tag, " busy"}, bus.busy, 1'b0);
        check({tag, " load_done"}, bus.load_done, 1'b0);
        check({tag, " load_err"}, bus.load_err, 1'b0);
        check({tag, " err_code"}, bus.err_code, 2'b00);
        check({tag, " cpu_hold"}, bus.cpu_hold, 1'b1);
    endtask

    initial begin
        int   w0;
        int   timeout_at;
        int   bad;
        logic [15:0] exp_w;

        n_checks     = 0;
        n_fail       = 0;
        wr_count     = 0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        reset        = 1'b0;

        vecs[0] = '{16'h1234, 16'hABCD, 8'h40, 1'b1, 1'b0, 2'b00, 1'b0};
        vecs[1] = '{16'h1234, 16'hABCD, 8'h41, 1'b0, 1'b1, 2'b01, 1'b1};
        vecs[2] = '{16'h0000, 16'hFFFF, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0};
        vecs[3] = '{16'hA5A5, 16'h0001, 8'h01, 1'b1, 1'b0, 2'b00, 1'b0};

        #23;
        check_reset_values("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("after release");

        for (int v = 0; v < 4; v++) begin
            w0 = wr_count;
            send(8'hA5);
            check($sformatf("v%0d header busy", v), bus.busy, 1'b1);
            check($sformatf("v%0d header clears done", v), bus.load_done, 1'b0);
            send(8'h02);
            send(vecs[v].w0[15:8]);
            send(vecs[v].w0[7:0]);
            check($sformatf("v%0d first we", v), {bus.mem_we, bus.mem_addr}, {1'b1, 8'h00});
            send(vecs[v].w1[15:8]);
            send(vecs[v].w1[7:0]);
            send(vecs[v].csum);
            check($sformatf("v%0d done", v), bus.load_done, vecs[v].exp_done);
            check($sformatf("v%0d err", v), bus.load_err, vecs[v].exp_err);
            check($sformatf("v%0d code", v), bus.err_code, vecs[v].exp_code);
            check($sformatf("v%0d hold", v), bus.cpu_hold, vecs[v].exp_hold);
            check($sformatf("v%0d busy", v), bus.busy, 1'b0);
            check($sformatf("v%0d writes", v), wr_count - w0, 2);
            check($sformatf("v%0d word0", v), mem_seen[0], vecs[v].w0);
            check($sformatf("v%0d word1", v), mem_seen[1], vecs[v].w1);
            check($sformatf("v%0d addr", v), bus.mem_addr, 8'h02);
        end

        // Garbage after DONE is ignored.
        send(8'h00);
        send(8'hFF);
        send(8'h5A);
        check("garbage keeps done", bus.load_done, 1'b1);
        check("garbage not busy", bus.busy, 1'b0);

        // Timeout with one orphan data byte.
        w0 = wr_count;
        send(8'hA5);
        send(8'h01);
        send(8'h55);
        timeout_at = -1;
        for (int i = 1; i <= int'(TO) + 5; i++) begin
            @(posedge clk);
            #1;
            if (bus.load_err === 1'b1) begin
                timeout_at = i;
                break;
            end
        end
        check("timeout edge", timeout_at, TO);
        check("timeout code", bus.err_code, 2'b10);
        check("timeout busy", bus.busy, 1'b0);
        check("timeout hold", bus.cpu_hold, 1'b1);
        check("timeout no write", wr_count - w0, 0);

        // Byte on the expiry edge wins.
        send(8'hA5);
        repeat (TO - 1) @(posedge clk);
        #1;
        send(8'h01);
        check("boundary no err", bus.load_err, 1'b0);
        check("boundary busy", bus.busy, 1'b1);
        send(8'h12);
        send(8'h34);
        send(8'h26);
        check("boundary done", bus.load_done, 1'b1);
        check("boundary word", mem_seen[0], 16'h1234);

        // 256-word frame, all back-to-back.
        w0 = wr_count;
        send(8'hA5);
        send(8'h00);
        for (int i = 0; i < 512; i++) send(i[7:0]);
        send(8'h00);
        check("n256 done", bus.load_done, 1'b1);
        check("n256 hold", bus.cpu_hold, 1'b0);
        check("n256 writes", wr_count - w0, 256);
        check("n256 addr wrap", bus.mem_addr, 8'h00);
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            exp_w = {8'(2 * a), 8'(2 * a + 1)};
            if (mem_seen[a] !== exp_w) bad++;
        end
        check("n256 contents", bad, 0);

        // Reset asserted while in DATA_LO.
        w0 = wr_count;
        send(8'hA5);
        send(8'h02);
        send(8'h12);
        send(8'h34);
        send(8'hAB);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("midreset");
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset one write", wr_count - w0, 1);
        w0 = wr_count;
        send(8'hA5);
        send(8'h02);
        send(8'h9A);
        send(8'hBC);
        check("reload addr 0", {bus.mem_we, bus.mem_addr}, {1'b1, 8'h00});
        send(8'hDE);
        send(8'hF0);
        send(8'h9A ^ 8'hBC ^ 8'hDE ^ 8'hF0);
        check("reload done", bus.load_done, 1'b1);
        check("reload writes", wr_count - w0, 2);
        check("reload word0", mem_seen[0], 16'h9ABC);
        check("reload word1", mem_seen[1], 16'hDEF0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
